// File: rtl/pc_rx_pkg.sv
// Shared types and helpers for the PC-side UART word receive path.
package pc_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int COUNT_WIDTH = 16;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pc_rx_word_fifo_if.sv
// Consumer-facing bundle of the word FIFO: pop/flush commands, head word, status and counters.
interface pc_rx_word_fifo_if #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 16
);
  localparam int WORD_WIDTH  = 8 * BYTES_PER_WORD;
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                                i_flush;
  logic                                i_read_next_word_cmd;
  logic [WORD_WIDTH-1:0]               o_fifo_output_word;
  logic                                o_fifo_is_empty_sig;
  logic                                o_fifo_full_sig;
  logic [LEVEL_WIDTH-1:0]              o_fifo_level;
  logic                                o_word_recv_sig;
  logic                                o_timeout_sig;
  logic [pc_rx_pkg::COUNT_WIDTH-1:0]   o_overflow_count;
  logic [pc_rx_pkg::COUNT_WIDTH-1:0]   o_framing_error_count;

  modport slave (
    input  i_flush, i_read_next_word_cmd,
    output o_fifo_output_word, o_fifo_is_empty_sig, o_fifo_full_sig, o_fifo_level,
           o_word_recv_sig, o_timeout_sig, o_overflow_count, o_framing_error_count
  );

  modport master (
    output i_flush, i_read_next_word_cmd,
    input  o_fifo_output_word, o_fifo_is_empty_sig, o_fifo_full_sig, o_fifo_level,
           o_word_recv_sig, o_timeout_sig, o_overflow_count, o_framing_error_count
  );
endinterface

// File: rtl/pc_uart_rx_core.sv
// Synchronises the UART line and deserialises 8N1 frames into bytes.
// One byte_valid pulse per good frame, one framing_error pulse per low stop bit.
module pc_uart_rx_core
  import pc_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 435
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       framing_error
);
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta, rx_sync;
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] clk_count;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             bit_end, half_end, data_sample, stop_ok, stop_bad, count_clear;

  // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
  // Idle-high reset value keeps a reset from looking like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_sync) state_next = START;
      START:     if (half_end) state_next = rx_sync ? IDLE : DATA;
      DATA:      if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:      if (bit_end) state_next = rx_sync ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    bit_end     = (clk_count == BIT_LAST);
    half_end    = (clk_count == HALF_LAST);
    data_sample = (state == DATA) && bit_end;
    stop_ok     = (state == STOP) && bit_end && rx_sync;
    stop_bad    = (state == STOP) && bit_end && !rx_sync;
    count_clear = (state == IDLE) || (state == WAIT_IDLE) || ((state == START) && half_end)
                  || data_sample || ((state == STOP) && bit_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_count     <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      byte_valid    <= stop_ok;
      framing_error <= stop_bad;
      clk_count     <= count_clear ? '0 : clk_count + 1'b1;
      if (state == IDLE) begin
        bit_idx <= '0;
      end else if (data_sample) begin
        bit_idx   <= bit_idx + 1'b1;
        shift_reg <= {rx_sync, shift_reg[7:1]};
      end
    end
  end

  assign rx_byte = shift_reg;

endmodule

// File: rtl/pc_rx_word_fifo.sv
// UART receive path: bytes are packed into words, which queue in a first-word-fall-through FIFO.
// Partial words are dropped on inter-byte timeout, framing error or flush.
module pc_rx_word_fifo
  import pc_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 435,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_BITS   = 20,
  parameter bit BIG_ENDIAN     = 1'b1
) (
  input logic              i_clock,
  input logic              i_reset_n,
  input logic              i_rx_serial,
  pc_rx_word_fifo_if.slave bus
);
  localparam int WORD_W    = 8 * BYTES_PER_WORD;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam int IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [7:0]             rx_byte;
  logic                   byte_valid, framing_error;
  logic [IDX_W-1:0]       byte_idx;
  logic [TMO_W-1:0]       tmo_count;
  logic [WORD_W-1:0]      word_acc, word_next;
  logic                   word_recv, timeout_pulse;
  logic [WORD_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [LVL_W-1:0]       level;
  logic [COUNT_WIDTH-1:0] overflow_count, framing_count;
  logic                   flush, empty, full, do_push, do_pop, overflow_evt;

  pc_uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_core (
    .clk           (i_clock),
    .rst_n         (i_reset_n),
    .rx_serial     (i_rx_serial),
    .rx_byte       (rx_byte),
    .byte_valid    (byte_valid),
    .framing_error (framing_error)
  );

  always_comb begin
    word_next = word_acc;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (int'(byte_idx) == k)
        word_next[(BIG_ENDIAN ? 8 * (BYTES_PER_WORD - 1 - k) : 8 * k) +: 8] = rx_byte;
    end
  end

  // Timeout only runs while a word is partially assembled.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      byte_idx      <= '0;
      tmo_count     <= '0;
      word_acc      <= '0;
      word_recv     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      word_recv     <= 1'b0;
      timeout_pulse <= 1'b0;
      if (flush) begin
        byte_idx  <= '0;
        tmo_count <= '0;
      end else if (byte_valid) begin
        word_acc  <= word_next;
        tmo_count <= '0;
        if (byte_idx == LAST_IDX) begin
          byte_idx  <= '0;
          word_recv <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (framing_error) begin
        byte_idx  <= '0;
        tmo_count <= '0;
      end else if (byte_idx != '0) begin
        if (tmo_count == TMO_LAST) begin
          byte_idx      <= '0;
          tmo_count     <= '0;
          timeout_pulse <= 1'b1;
        end else begin
          tmo_count <= tmo_count + 1'b1;
        end
      end
    end
  end

  assign flush        = bus.i_flush;
  assign empty        = (level == '0);
  assign full         = (level == FULL_LVL);
  assign do_pop       = bus.i_read_next_word_cmd && !empty && !flush;
  assign do_push      = word_recv && !flush && (!full || do_pop);
  assign overflow_evt = word_recv && !flush && full && !do_pop;

  // NOTE: storage has no reset; level tracks validity and the head is masked while empty.
  always_ff @(posedge i_clock) begin
    if (do_push) mem[wr_ptr] <= word_acc;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      overflow_count <= '0;
      framing_count  <= '0;
    end else begin
      if (overflow_evt)  overflow_count <= sat_inc(overflow_count);
      if (framing_error) framing_count  <= sat_inc(framing_count);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  assign bus.o_fifo_output_word    = empty ? '0 : mem[rd_ptr];
  assign bus.o_fifo_is_empty_sig   = empty;
  assign bus.o_fifo_full_sig       = full;
  assign bus.o_fifo_level          = level;
  assign bus.o_word_recv_sig       = word_recv;
  assign bus.o_timeout_sig         = timeout_pulse;
  assign bus.o_overflow_count      = overflow_count;
  assign bus.o_framing_error_count = framing_count;

endmodule

// File: tb/tb_pc_rx_word_fifo.sv
// Bench for pc_rx_word_fifo: big- and little-endian instances share one serial line and
// are compared every settled cycle against a queue-based word model.
module tb_pc_rx_word_fifo;
  localparam int CPB   = 16;
  localparam int BPW   = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_line;

  always #5 clk = ~clk;

  pc_rx_word_fifo_if #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH)) bus_be ();
  pc_rx_word_fifo_if #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH)) bus_le ();

  pc_rx_word_fifo #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH),
                    .TIMEOUT_BITS(TMO), .BIG_ENDIAN(1'b1)) dut_be (
    .i_clock(clk), .i_reset_n(rst_n), .i_rx_serial(rx_line), .bus(bus_be));

  pc_rx_word_fifo #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH),
                    .TIMEOUT_BITS(TMO), .BIG_ENDIAN(1'b0)) dut_le (
    .i_clock(clk), .i_reset_n(rst_n), .i_rx_serial(rx_line), .bus(bus_le));

  int n_tests = 0;
  int n_fail  = 0;
  logic check_en = 1'b0;

  // Model: words stored first-byte-in-MSB; little-endian view is the byte swap.
  logic [31:0] mq[$];
  logic [31:0] part_w = '0;
  int part_n = 0;
  int exp_ovf = 0, exp_fe = 0, exp_words = 0, exp_tmo = 0;
  int got_words_be = 0, got_words_le = 0, got_tmo_be = 0, got_tmo_le = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] ib;
    ib = 8'(i);
    return {ib, 8'hA5, 8'(ib * 3), 8'h5A};
  endfunction

  initial forever begin
    @(negedge clk);
    if (bus_be.o_word_recv_sig) got_words_be++;
    if (bus_le.o_word_recv_sig) got_words_le++;
    if (bus_be.o_timeout_sig)   got_tmo_be++;
    if (bus_le.o_timeout_sig)   got_tmo_le++;
    if (check_en) begin
      check("be_empty", bus_be.o_fifo_is_empty_sig, mq.size() == 0);
      check("le_empty", bus_le.o_fifo_is_empty_sig, mq.size() == 0);
      check("be_full", bus_be.o_fifo_full_sig, mq.size() == DEPTH);
      check("le_full", bus_le.o_fifo_full_sig, mq.size() == DEPTH);
      check("be_level", bus_be.o_fifo_level, mq.size());
      check("le_level", bus_le.o_fifo_level, mq.size());
      if (mq.size() != 0) begin
        check("be_head", bus_be.o_fifo_output_word, mq[0]);
        check("le_head", bus_le.o_fifo_output_word, swap32(mq[0]));
      end
      check("be_overflow", bus_be.o_overflow_count, exp_ovf);
      check("le_overflow", bus_le.o_overflow_count, exp_ovf);
      check("be_framing", bus_be.o_framing_error_count, exp_fe);
      check("le_framing", bus_le.o_framing_error_count, exp_fe);
      check("be_word_pulses", got_words_be, exp_words);
      check("le_word_pulses", got_words_le, exp_words);
      check("be_timeouts", got_tmo_be, exp_tmo);
      check("le_timeouts", got_tmo_le, exp_tmo);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pop(input logic v);
    bus_be.i_read_next_word_cmd = v;
    bus_le.i_read_next_word_cmd = v;
  endtask

  task automatic set_flush(input logic v);
    bus_be.i_flush = v;
    bus_le.i_flush = v;
  endtask

  task automatic line_bit(input logic v);
    rx_line = v;
    tick(CPB);
  endtask

  task automatic model_byte(input logic [7:0] b);
    part_w = {part_w[23:0], b};
    part_n++;
    if (part_n == BPW) begin
      part_n = 0;
      exp_words++;
      if (mq.size() == DEPTH) exp_ovf++;
      else mq.push_back(part_w);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    check_en = 1'b0;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(1'b1);
    tick(4);
    model_byte(b);
    check_en = 1'b1;
    tick(CPB);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic pop_word();
    set_pop(1'b1);
    tick(1);
    set_pop(1'b0);
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic flush_fifo();
    set_flush(1'b1);
    tick(1);
    set_flush(1'b0);
    mq.delete();
    part_n = 0;
  endtask

  // Last byte's word is pushed with a pop in the same cycle as o_word_recv_sig.
  task automatic send_word_pop_at_push(input logic [31:0] w);
    logic seen;
    seen = 1'b0;
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    check_en = 1'b0;
    fork
      begin
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(w[i]);
        line_bit(1'b1);
      end
      begin
        for (int c = 0; c < 12 * CPB && !seen; c++) begin
          @(posedge clk);
          #1;
          if (bus_be.o_word_recv_sig) begin
            seen = 1'b1;
            set_pop(1'b1);
            tick(1);
            set_pop(1'b0);
          end
        end
      end
    join
    check("pushpop_recv_seen", seen, 1'b1);
    tick(4);
    exp_words++;
    part_n = 0;
    part_w = w;
    void'(mq.pop_front());
    mq.push_back(w);
    check_en = 1'b1;
    tick(CPB);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rx_line = 1'b1;
    set_pop(1'b0);
    set_flush(1'b0);
    tick(3);
    check("rst_empty", bus_be.o_fifo_is_empty_sig, 1'b1);
    check("rst_level", bus_be.o_fifo_level, 0);
    check("rst_word", bus_be.o_fifo_output_word, 32'h0);
    check("rst_full", bus_be.o_fifo_full_sig, 1'b0);
    rst_n = 1'b1;
    tick(2);
    check_en = 1'b1;

    // Basic word, both byte orders.
    send_word(32'h12345678);
    check("t1_be_head", bus_be.o_fifo_output_word, 32'h12345678);
    check("t1_le_head", bus_le.o_fifo_output_word, 32'h78563412);
    check("t1_level", bus_be.o_fifo_level, 1);
    pop_word();
    pop_word();
    tick(2);

    // Overflow: 18 words with no pops, then drain 16.
    for (int i = 0; i < 18; i++) send_word(word_of(i));
    check("t2_full", bus_be.o_fifo_full_sig, 1'b1);
    check("t2_overflow", bus_be.o_overflow_count, 2);
    check("t2_first_head", bus_be.o_fifo_output_word, 32'h00A5005A);
    for (int i = 0; i < 16; i++) begin
      pop_word();
      tick(1);
    end
    check("t2_drained", bus_be.o_fifo_is_empty_sig, 1'b1);

    // Start-bit glitch shorter than half a bit: nothing received.
    rx_line = 1'b0;
    tick(5);
    rx_line = 1'b1;
    tick(2 * CPB);

    // Refill, then push+pop at full; then drain to 5 and flush.
    for (int i = 0; i < 16; i++) send_word(word_of(32 + i));
    send_word_pop_at_push(32'hDEADBEEF);
    check("t5_level_full", bus_be.o_fifo_level, 16);
    check("t5_no_overflow", bus_be.o_overflow_count, 2);
    for (int i = 0; i < 11; i++) pop_word();
    tick(1);
    check("t6_level5", bus_be.o_fifo_level, 5);
    flush_fifo();
    check("t6_flush_empty", bus_be.o_fifo_is_empty_sig, 1'b1);
    check("t6_flush_level", bus_be.o_fifo_level, 0);
    check("t6_flush_keeps_ovf", bus_be.o_overflow_count, 2);
    tick(2);

    // Inter-byte timeout discards a partial word.
    send_byte(8'hEE);
    send_byte(8'hEE);
    check_en = 1'b0;
    tick(25 * CPB);
    part_n = 0;
    exp_tmo++;
    check_en = 1'b1;
    tick(1);
    check("t3_one_timeout", got_tmo_be, 1);
    send_word(32'hAABBCCDD);
    check("t3_be_head", bus_be.o_fifo_output_word, 32'hAABBCCDD);
    check("t3_le_head", bus_le.o_fifo_output_word, 32'hDDCCBBAA);
    pop_word();

    // Framing error drops the partial word; line held low (break) before recovery.
    send_byte(8'h12);
    check_en = 1'b0;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(1'((8'h34 >> i) & 8'h01));
    line_bit(1'b0);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b1);
    exp_fe++;
    part_n = 0;
    check_en = 1'b1;
    tick(1);
    send_word(32'h01020304);
    check("t4_framing", bus_be.o_framing_error_count, 1);
    check("t4_level", bus_be.o_fifo_level, 1);
    check("t4_head", bus_be.o_fifo_output_word, 32'h01020304);

    // Reset in the middle of a data bit.
    check_en = 1'b0;
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    rst_n = 1'b0;
    #2;
    check("t6_rst_empty", bus_be.o_fifo_is_empty_sig, 1'b1);
    check("t6_rst_level", bus_be.o_fifo_level, 0);
    check("t6_rst_word", bus_be.o_fifo_output_word, 32'h0);
    check("t6_rst_ovf", bus_be.o_overflow_count, 0);
    check("t6_rst_fe", bus_be.o_framing_error_count, 0);
    check("t6_rst_recv", bus_be.o_word_recv_sig, 1'b0);
    check("t6_rst_le_ovf", bus_le.o_overflow_count, 0);
    rx_line = 1'b1;
    tick(3);
    mq.delete();
    part_n  = 0;
    exp_ovf = 0;
    exp_fe  = 0;
    rst_n   = 1'b1;
    tick(2 * CPB);
    check_en = 1'b1;
    send_word(32'hC0FFEE11);
    check("t6_post_rst_head", bus_be.o_fifo_output_word, 32'hC0FFEE11);
    check("t6_post_rst_le_head", bus_le.o_fifo_output_word, 32'h11EEFFC0);
    check("t6_post_rst_level", bus_be.o_fifo_level, 1);

    check_en = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
